// File: rtl/risc_toy_pkg.sv
// Shared definitions for the RISC_TOY pipeline: widths, opcodes, bubble pattern.
package risc_toy_pkg;

  // Instruction word address width and data width.
  localparam int unsigned IAW = 30;
  localparam int unsigned DW  = 32;

  // Opcode field position inside an instruction word.
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;

  // 5-bit opcodes; 5'b00000 is deliberately unused so an all-zero word is a no-op.
  typedef enum logic [4:0] {
    OpNone = 5'd0,
    OpAddi = 5'd1,
    OpAndi = 5'd2,
    OpOri  = 5'd3,
    OpMovi = 5'd4,
    OpAdd  = 5'd5,
    OpSub  = 5'd6,
    OpNeg  = 5'd7,
    OpNot  = 5'd8,
    OpAnd  = 5'd9,
    OpOr   = 5'd10,
    OpXor  = 5'd11,
    OpLsr  = 5'd12,
    OpAsr  = 5'd13,
    OpShl  = 5'd14,
    OpRor  = 5'd15,
    OpBr   = 5'd16,
    OpBrl  = 5'd17,
    OpJ    = 5'd18,
    OpJl   = 5'd19,
    OpLd   = 5'd20,
    OpLdr  = 5'd21,
    OpSt   = 5'd22,
    OpStr  = 5'd23
  } opcode_e;

  // Bubble pattern inserted into IF/ID when no real instruction is present.
  localparam logic [DW-1:0] NOP_INSTR_C = 32'h0000_0000;

  // Byte address of the instruction following word address addr.
  function automatic logic [DW-1:0] link_addr(input logic [IAW-1:0] addr);
    logic [IAW-1:0] next_addr;
    next_addr = addr + IAW'(1);
    return {next_addr, 2'b00};
  endfunction

  // Extract the opcode field of an instruction word.
  function automatic opcode_e get_opcode(input logic [DW-1:0] instr);
    return opcode_e'(instr[OP_MSB:OP_LSB]);
  endfunction

endpackage

// File: rtl/risc_toy_fetch_skid.sv
// One-entry hold buffer that catches a memory response arriving while decode stalls.
module risc_toy_fetch_skid
  import risc_toy_pkg::*;
(
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           clear,
  input  logic           load,
  input  logic           drain,
  input  logic [DW-1:0]  load_instr,
  input  logic [IAW-1:0] load_addr,
  output logic           valid,
  output logic [DW-1:0]  instr,
  output logic [IAW-1:0] addr
);

  logic           valid_q, valid_d;
  logic [DW-1:0]  instr_q, instr_d;
  logic [IAW-1:0] addr_q, addr_d;

  // Next-state: clear beats load beats drain; payload only changes on load.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      addr_d  = load_addr;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // Buffer state register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR_C;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign addr  = addr_q;

endmodule

// File: rtl/risc_toy_fetch.sv
// Instruction-fetch stage: owns the PC, issues memory requests, fills the IF/ID register.
module risc_toy_fetch
  import risc_toy_pkg::*;
#(
  parameter logic [IAW-1:0] RESET_PC  = 30'h0,
  parameter logic [DW-1:0]  NOP_INSTR = NOP_INSTR_C
) (
  input  logic           CLK,
  input  logic           RSTN,
  output logic           IREQ,
  output logic [IAW-1:0] IADDR,
  input  logic [DW-1:0]  INSTR,
  input  logic           STALL,
  input  logic           REDIRECT,
  input  logic [IAW-1:0] REDIRECT_PC,
  output logic           IF_VALID,
  output logic [DW-1:0]  IF_INSTR,
  output logic [IAW-1:0] IF_IADDR,
  output logic [DW-1:0]  IF_LINK
);

  logic [IAW-1:0] pc_q, pc_d;
  logic           req_q, req_d;
  logic [IAW-1:0] req_addr_q, req_addr_d;
  logic           if_valid_q, if_valid_d;
  logic [DW-1:0]  if_instr_q, if_instr_d;
  logic [IAW-1:0] if_iaddr_q, if_iaddr_d;

  logic           ireq;
  logic           skid_valid;
  logic [DW-1:0]  skid_instr;
  logic [IAW-1:0] skid_addr;
  logic           skid_clear, skid_load, skid_drain;

  // Request gating: a full skid, or a stall with a response landing, means nowhere to put more.
  always_comb begin
    ireq = RSTN & ~skid_valid & ~(STALL & req_q);
  end

  assign IREQ  = ireq;
  assign IADDR = pc_q;

  // Skid control; redirect discards held data, stall captures the arriving response.
  always_comb begin
    skid_clear = REDIRECT;
    skid_load  = ~REDIRECT & STALL & req_q;
    skid_drain = ~REDIRECT & ~STALL & skid_valid;
  end

  risc_toy_fetch_skid u_skid (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .clear      (skid_clear),
    .load       (skid_load),
    .drain      (skid_drain),
    .load_instr (INSTR),
    .load_addr  (req_addr_q),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .addr       (skid_addr)
  );

  // PC and in-flight tracking; a redirect kills whatever response is on its way.
  always_comb begin
    pc_d       = pc_q;
    req_d      = ireq;
    req_addr_d = req_addr_q;
    if (REDIRECT) begin
      pc_d  = REDIRECT_PC;
      req_d = 1'b0;
    end else if (ireq) begin
      pc_d       = pc_q + IAW'(1);
      req_addr_d = pc_q;
    end
  end

  // IF/ID next state in priority order: redirect, stall, skid drain, live response, bubble.
  always_comb begin
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_iaddr_d = if_iaddr_q;
    if (REDIRECT) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end else if (STALL) begin
      // hold
    end else if (skid_valid) begin
      if_valid_d = 1'b1;
      if_instr_d = skid_instr;
      if_iaddr_d = skid_addr;
    end else if (req_q) begin
      if_valid_d = 1'b1;
      if_instr_d = INSTR;
      if_iaddr_d = req_addr_q;
    end else begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end
  end

  // PC and request tracking registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      req_addr_q <= '0;
    end else begin
      pc_q       <= pc_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_iaddr_q <= '0;
    end else begin
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_iaddr_q <= if_iaddr_d;
    end
  end

  assign IF_VALID = if_valid_q;
  assign IF_INSTR = if_instr_q;
  assign IF_IADDR = if_iaddr_q;
  assign IF_LINK  = link_addr(if_iaddr_q);

endmodule

// File: tb/tb_risc_toy_fetch.sv
// Directed bench for risc_toy_fetch: stream, stall/skid, redirect, wrap and mid-run reset.
module tb_risc_toy_fetch;

  logic        CLK;
  logic        RSTN;
  logic        IREQ;
  logic [29:0] IADDR;
  logic [31:0] INSTR;
  logic        STALL;
  logic        REDIRECT;
  logic [29:0] REDIRECT_PC;
  logic        IF_VALID;
  logic [31:0] IF_INSTR;
  logic [29:0] IF_IADDR;
  logic [31:0] IF_LINK;

  int n_pass  = 0;
  int n_total = 0;

  logic [29:0] mem_addr;

  risc_toy_fetch #(
    .RESET_PC  (30'h0),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .IREQ        (IREQ),
    .IADDR       (IADDR),
    .INSTR       (INSTR),
    .STALL       (STALL),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .IF_VALID    (IF_VALID),
    .IF_INSTR    (IF_INSTR),
    .IF_IADDR    (IF_IADDR),
    .IF_LINK     (IF_LINK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: latch the requested address, return a pattern derived from it next cycle.
  always @(posedge CLK) begin
    if (IREQ) mem_addr <= IADDR;
  end
  assign INSTR = 32'h1000_0000 | {2'b00, mem_addr};

  function automatic logic [31:0] pat(input logic [29:0] a);
    return 32'h1000_0000 | {2'b00, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // req_q and a full skid must never coexist.
  always @(negedge CLK) begin
    if (RSTN === 1'b1) chk("invariant_req_skid", {31'b0, dut.req_q & dut.skid_valid}, 32'h0);
  end

  initial begin
    mem_addr    = '0;
    RSTN        = 1'b0;
    STALL       = 1'b0;
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;
    step();
    step();
    chk("rst_ireq",     {31'b0, IREQ}, 32'h0);
    chk("rst_iaddr",    {2'b0, IADDR}, 32'h0);
    chk("rst_if_valid", {31'b0, IF_VALID}, 32'h0);
    chk("rst_if_instr", IF_INSTR, 32'h0);
    chk("rst_if_iaddr", {2'b0, IF_IADDR}, 32'h0);
    chk("rst_if_link",  IF_LINK, 32'h4);

    // Release reset; first valid two edges later.
    RSTN = 1'b1;
    #1;
    chk("rel_ireq", {31'b0, IREQ}, 32'h1);
    step();
    chk("e1_if_valid", {31'b0, IF_VALID}, 32'h0);
    chk("e1_iaddr",    {2'b0, IADDR}, 32'h1);
    step();
    chk("e2_if_valid", {31'b0, IF_VALID}, 32'h1);
    chk("e2_if_iaddr", {2'b0, IF_IADDR}, 32'h0);
    chk("e2_if_instr", IF_INSTR, 32'h1000_0000);
    chk("e2_if_link",  IF_LINK, 32'h4);
    chk("e2_iaddr",    {2'b0, IADDR}, 32'h2);

    // Free run up to IF/ID holding address 5.
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("run_valid", {31'b0, IF_VALID}, 32'h1);
      chk("run_iaddr", {2'b0, IF_IADDR}, i);
      chk("run_instr", IF_INSTR, pat(30'(i)));
    end

    // Stall three cycles; response for 6 goes to the skid.
    STALL = 1'b1;
    #1;
    chk("stall_ireq_drop", {31'b0, IREQ}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_iaddr", {2'b0, IF_IADDR}, 32'h5);
      chk("stall_hold_valid", {31'b0, IF_VALID}, 32'h1);
      chk("stall_ireq",       {31'b0, IREQ}, 32'h0);
    end
    STALL = 1'b0;
    step();
    chk("drain_iaddr", {2'b0, IF_IADDR}, 32'h6);
    chk("drain_instr", IF_INSTR, pat(30'h6));
    chk("drain_valid", {31'b0, IF_VALID}, 32'h1);
    chk("drain_iaddr_req", {2'b0, IADDR}, 32'h7);
    step();
    chk("refill_bubble", {31'b0, IF_VALID}, 32'h0);
    step();
    chk("after_stall_7", {2'b0, IF_IADDR}, 32'h7);
    chk("after_stall_7v", {31'b0, IF_VALID}, 32'h1);
    step();
    chk("after_stall_8", {2'b0, IF_IADDR}, 32'h8);
    chk("after_stall_8i", IF_INSTR, pat(30'h8));

    // Redirect to 0x40 while address 9 is in flight.
    REDIRECT    = 1'b1;
    REDIRECT_PC = 30'h40;
    step();
    REDIRECT = 1'b0;
    #1;
    chk("redir_valid", {31'b0, IF_VALID}, 32'h0);
    chk("redir_nop",   IF_INSTR, 32'h0);
    chk("redir_iaddr", {2'b0, IADDR}, 32'h40);
    chk("redir_ireq",  {31'b0, IREQ}, 32'h1);
    step();
    chk("redir_no9", {31'b0, IF_VALID}, 32'h0);
    step();
    chk("redir_tgt_iaddr", {2'b0, IF_IADDR}, 32'h40);
    chk("redir_tgt_instr", IF_INSTR, pat(30'h40));
    chk("redir_tgt_valid", {31'b0, IF_VALID}, 32'h1);

    // Fill the skid, then redirect with stall still high.
    STALL = 1'b1;
    step();
    chk("skid_hold", {2'b0, IF_IADDR}, 32'h40);
    chk("skid_ireq", {31'b0, IREQ}, 32'h0);
    REDIRECT    = 1'b1;
    REDIRECT_PC = 30'h3FFF_FFFE;
    step();
    REDIRECT = 1'b0;
    #1;
    chk("rs_valid",      {31'b0, IF_VALID}, 32'h0);
    chk("rs_nop",        IF_INSTR, 32'h0);
    chk("rs_skid_clear", {31'b0, dut.skid_valid}, 32'h0);
    chk("rs_iaddr",      {2'b0, IADDR}, 32'h3FFF_FFFE);
    chk("rs_ireq",       {31'b0, IREQ}, 32'h1);
    STALL = 1'b0;

    // PC wrap at the top of the address space.
    step();
    chk("wrap_iaddr_ff", {2'b0, IADDR}, 32'h3FFF_FFFF);
    chk("wrap_bubble",   {31'b0, IF_VALID}, 32'h0);
    step();
    chk("wrap_iaddr_0",  {2'b0, IADDR}, 32'h0);
    chk("wrap_if_fe",    {2'b0, IF_IADDR}, 32'h3FFF_FFFE);
    chk("wrap_link_fe",  IF_LINK, 32'hFFFF_FFFC);
    step();
    chk("wrap_if_ff",    {2'b0, IF_IADDR}, 32'h3FFF_FFFF);
    chk("wrap_link_ff",  IF_LINK, 32'h0);
    chk("wrap_iaddr_1",  {2'b0, IADDR}, 32'h1);

    // Mid-stream reset takes effect without a clock edge.
    RSTN = 1'b0;
    #1;
    chk("mrst_ireq",  {31'b0, IREQ}, 32'h0);
    chk("mrst_valid", {31'b0, IF_VALID}, 32'h0);
    chk("mrst_instr", IF_INSTR, 32'h0);
    chk("mrst_iaddr", {2'b0, IADDR}, 32'h0);
    step();
    RSTN = 1'b1;
    step();
    chk("restart_e1_valid", {31'b0, IF_VALID}, 32'h0);
    chk("restart_e1_iaddr", {2'b0, IADDR}, 32'h1);
    step();
    chk("restart_valid", {31'b0, IF_VALID}, 32'h1);
    chk("restart_iaddr", {2'b0, IF_IADDR}, 32'h0);
    chk("restart_instr", IF_INSTR, 32'h1000_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
